// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, sequencer FSM encoding and default widths.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 4;

    localparam logic [3:0] ALU_SLL  = 4'b0000;
    localparam logic [3:0] ALU_SRL  = 4'b0001;
    localparam logic [3:0] ALU_SRA  = 4'b0010;
    localparam logic [3:0] ALU_SLLV = 4'b0011;
    localparam logic [3:0] ALU_SRLV = 4'b0100;
    localparam logic [3:0] ALU_SRAV = 4'b0101;
    localparam logic [3:0] ALU_ADDU = 4'b0110;
    localparam logic [3:0] ALU_SUBU = 4'b0111;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1011;
    localparam logic [3:0] ALU_SLT  = 4'b1100;
    localparam logic [3:0] ALU_JALR = 4'b1101;
    localparam logic [3:0] ALU_LUI  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Two-way round-robin arbiter: one-hot grant from the valids and priority pointer.
module rr_arbiter_2 (
    input  logic       valid_0_i,
    input  logic       valid_1_i,
    input  logic       ptr_i,
    input  logic       en_i,
    output logic [1:0] grant_o,
    output logic       next_ptr_o
);

    // Grant the lone requester, or the pointed-to one on contention; pointer then moves past the winner.
    always_comb begin
        grant_o    = 2'b00;
        next_ptr_o = ptr_i;
        if (en_i) begin
            case ({valid_1_i, valid_0_i})
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = ptr_i ? 2'b10 : 2'b01;
                default: grant_o = 2'b00;
            endcase
        end else begin
            grant_o = 2'b00;
        end
        if (grant_o[0]) begin
            next_ptr_o = 1'b1;
        end else if (grant_o[1]) begin
            next_ptr_o = 1'b0;
        end else begin
            next_ptr_o = ptr_i;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters: accept, execute, respond.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_Req_Valid_0,
    output logic              o_Req_Ready_0,
    input  logic [CTRL_W-1:0] i_Req_Control_0,
    input  logic [DATA_W-1:0] i_Req_Data_1_0,
    input  logic [DATA_W-1:0] i_Req_Data_2_0,
    input  logic [4:0]        i_Req_Shamt_0,
    output logic              o_Rsp_Valid_0,
    input  logic              i_Rsp_Ready_0,
    output logic [DATA_W-1:0] o_Rsp_Result_0,
    input  logic              i_Req_Valid_1,
    output logic              o_Req_Ready_1,
    input  logic [CTRL_W-1:0] i_Req_Control_1,
    input  logic [DATA_W-1:0] i_Req_Data_1_1,
    input  logic [DATA_W-1:0] i_Req_Data_2_1,
    input  logic [4:0]        i_Req_Shamt_1,
    output logic              o_Rsp_Valid_1,
    input  logic              i_Rsp_Ready_1,
    output logic [DATA_W-1:0] o_Rsp_Result_1,
    output logic [CTRL_W-1:0] o_ALU_Control,
    output logic [DATA_W-1:0] o_ALU_Data_1,
    output logic [DATA_W-1:0] o_ALU_Data_2,
    output logic [4:0]        o_ALU_Shamt,
    input  logic [DATA_W-1:0] i_ALU_Result,
    output logic              o_Busy
);

    state_e            state_q, state_d;
    logic              ptr_q;
    logic              owner_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_1_q;
    logic [DATA_W-1:0] data_2_q;
    logic [4:0]        shamt_q;
    logic [DATA_W-1:0] result_q;

    logic [1:0]        grant_s;
    logic              next_ptr_s;
    logic              accept_s;
    logic              rsp_ready_owner_s;

    // Arbitration is suppressed while reset is asserted so nothing is accepted in that cycle.
    rr_arbiter_2 u_rr (
        .valid_0_i  (i_Req_Valid_0),
        .valid_1_i  (i_Req_Valid_1),
        .ptr_i      (ptr_q),
        .en_i       ((state_q == ST_IDLE) && !i_reset),
        .grant_o    (grant_s),
        .next_ptr_o (next_ptr_s)
    );

    assign accept_s          = grant_s[0] | grant_s[1];
    assign rsp_ready_owner_s = owner_q ? i_Rsp_Ready_1 : i_Rsp_Ready_0;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = accept_s ? ST_EXEC : ST_IDLE;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: state_d = rsp_ready_owner_s ? ST_IDLE : ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand, owner, pointer and result registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            ctrl_q   <= {CTRL_W{1'b0}};
            data_1_q <= {DATA_W{1'b0}};
            data_2_q <= {DATA_W{1'b0}};
            shamt_q  <= 5'd0;
            result_q <= {DATA_W{1'b0}};
        end else begin
            if (accept_s) begin
                ptr_q    <= next_ptr_s;
                owner_q  <= grant_s[1];
                ctrl_q   <= grant_s[1] ? i_Req_Control_1 : i_Req_Control_0;
                data_1_q <= grant_s[1] ? i_Req_Data_1_1  : i_Req_Data_1_0;
                data_2_q <= grant_s[1] ? i_Req_Data_2_1  : i_Req_Data_2_0;
                shamt_q  <= grant_s[1] ? i_Req_Shamt_1   : i_Req_Shamt_0;
            end
            if (state_q == ST_EXEC) begin
                result_q <= i_ALU_Result;
            end
        end
    end

    // FSM outputs: request readies, owner-steered response and busy flag.
    always_comb begin
        o_Req_Ready_0  = grant_s[0];
        o_Req_Ready_1  = grant_s[1];
        o_Rsp_Valid_0  = 1'b0;
        o_Rsp_Valid_1  = 1'b0;
        o_Rsp_Result_0 = {DATA_W{1'b0}};
        o_Rsp_Result_1 = {DATA_W{1'b0}};
        o_Busy         = (state_q != ST_IDLE);
        if (state_q == ST_RESP) begin
            if (owner_q) begin
                o_Rsp_Valid_1  = 1'b1;
                o_Rsp_Result_1 = result_q;
            end else begin
                o_Rsp_Valid_0  = 1'b1;
                o_Rsp_Result_0 = result_q;
            end
        end else begin
            o_Rsp_Valid_0 = 1'b0;
            o_Rsp_Valid_1 = 1'b0;
        end
    end

    assign o_ALU_Control = ctrl_q;
    assign o_ALU_Data_1  = data_1_q;
    assign o_ALU_Data_2  = data_2_q;
    assign o_ALU_Shamt   = shamt_q;

endmodule
